// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------------
// counter_sequencer_pkg : state, direction and mode encodings.  Rev 1.0
// ------------------------------------------------------------------------
package counter_sequencer_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int PRESC_W_DEF = 8;
   localparam int CLR_CYC_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLR   = 2'd1,
      S_RUN   = 2'd2,
      S_PAUSE = 2'd3
   } seq_state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_prescaler.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------------
// seq_prescaler : step-rate divider, ticks when the phase reaches div.  Rev 1.0
// ------------------------------------------------------------------------
module seq_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               zero,
   input  logic               advance,
   input  logic [PRESC_W-1:0] div,
   output logic               tick
);

   logic [PRESC_W-1:0] count;

   assign tick = (count == div);

   // Without advance the phase holds, which is what lets a pause resume mid-period.
   always_ff @(posedge clk) begin
      if (rst || zero) begin
         count <= '0;
      end else if (advance) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------------
// counter_sequencer : step/clear/direction controller for an external counter.  Rev 1.0
// ------------------------------------------------------------------------
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int PRESC_W = PRESC_W_DEF,
   parameter int CLR_CYC = CLR_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_start,
   input  logic               cmd_stop,
   input  logic               cmd_clear,
   input  logic               cfg_dir,
   input  logic               cfg_mode,
   input  logic [CNT_W-1:0]   cfg_limit,
   input  logic [PRESC_W-1:0] cfg_div,
   input  logic [CNT_W-1:0]   cnt_val,
   output logic               cnt_step,
   output logic               cnt_dir,
   output logic               cnt_clr,
   output logic               busy,
   output logic               done,
   output logic [1:0]         state
);

   localparam int               CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

   seq_state_t         st;
   seq_state_t         dest;
   logic [CNT_W-1:0]   target;
   logic [PRESC_W-1:0] div_lat;
   logic               mode_lat;
   logic               done_flag;
   logic [CLR_W-1:0]   clr_cnt;
   logic               tick;
   logic               at_target;
   logic               presc_adv;
   logic               presc_zero;

   assign state      = st;
   assign at_target  = (cnt_val == target);
   assign presc_zero = (st == S_CLR);
   assign presc_adv  = (st == S_RUN) && !cmd_clear && !cmd_stop && !at_target;

   seq_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk     (clk),
      .rst     (rst),
      .zero    (presc_zero),
      .advance (presc_adv),
      .div     (div_lat),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IDLE;
         dest      <= S_IDLE;
         target    <= '0;
         div_lat   <= '0;
         mode_lat  <= MODE_ONESHOT;
         cnt_dir   <= DIR_UP;
         done_flag <= 1'b0;
         clr_cnt   <= '0;
         cnt_step  <= 1'b0;
         cnt_clr   <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cnt_step <= 1'b0;
         done     <= 1'b0;
         case (st)
            S_IDLE: begin
               done_flag <= done_flag & ~(cmd_start | cmd_clear);
               if (cmd_clear) begin
                  st      <= S_CLR;
                  dest    <= S_IDLE;
                  cnt_clr <= 1'b1;
                  clr_cnt <= '0;
                  busy    <= 1'b0;
               end else if (cmd_start) begin
                  // Down runs end at the two's-complement of the limit after clearing to 0.
                  target   <= (cfg_dir == DIR_DOWN) ? (~cfg_limit + 1'b1) : cfg_limit;
                  div_lat  <= (cfg_div == '0) ? PRESC_W'(1) : cfg_div;
                  mode_lat <= cfg_mode;
                  cnt_dir  <= cfg_dir;
                  st       <= S_CLR;
                  dest     <= S_RUN;
                  cnt_clr  <= 1'b1;
                  clr_cnt  <= '0;
                  busy     <= 1'b1;
               end
            end

            S_CLR: begin
               if (cmd_clear) begin
                  dest    <= S_IDLE;
                  clr_cnt <= '0;
                  busy    <= 1'b0;
               end else if (clr_cnt == CLR_LAST) begin
                  cnt_clr <= 1'b0;
                  st      <= dest;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end

            S_RUN: begin
               if (cmd_clear) begin
                  st      <= S_CLR;
                  dest    <= S_IDLE;
                  cnt_clr <= 1'b1;
                  clr_cnt <= '0;
                  busy    <= 1'b0;
               end else if (cmd_stop) begin
                  st <= S_PAUSE;
               end else if (at_target) begin
                  done <= 1'b1;
                  if (mode_lat == MODE_RELOAD) begin
                     st      <= S_CLR;
                     dest    <= S_RUN;
                     cnt_clr <= 1'b1;
                     clr_cnt <= '0;
                  end else begin
                     st        <= S_IDLE;
                     busy      <= 1'b0;
                     done_flag <= 1'b1;
                  end
               end else if (tick) begin
                  cnt_step <= 1'b1;
               end
            end

            S_PAUSE: begin
               if (cmd_clear) begin
                  st      <= S_CLR;
                  dest    <= S_IDLE;
                  cnt_clr <= 1'b1;
                  clr_cnt <= '0;
                  busy    <= 1'b0;
               end else if (!cmd_stop && cmd_start) begin
                  st <= S_RUN;
               end
            end

            default: begin
               st <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------------
// tb_counter_sequencer : directed bench with a behavioural up/down counter.  Rev 1.0
// ------------------------------------------------------------------------
module tb_counter_sequencer;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        cmd_start = 1'b0;
   logic        cmd_stop  = 1'b0;
   logic        cmd_clear = 1'b0;
   logic        cfg_dir   = 1'b0;
   logic        cfg_mode  = 1'b0;
   logic [15:0] cfg_limit = 16'd0;
   logic [7:0]  cfg_div   = 8'd0;
   logic [15:0] cnt_val;
   logic        cnt_step, cnt_dir, cnt_clr, busy, done;
   logic [1:0]  state;

   int tests = 0;
   int fails = 0;

   logic        mon_clear = 1'b0;
   int          step_cnt  = 0;
   int          done_cnt  = 0;
   int          clr_hi    = 0;
   int          cyc       = 0;
   int          last_step = -1;
   int          min_gap   = 9999;
   int          max_gap   = 0;
   logic [15:0] model     = 16'd0;

   assign cnt_val = model;

   counter_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .cmd_clear (cmd_clear),
      .cfg_dir   (cfg_dir),
      .cfg_mode  (cfg_mode),
      .cfg_limit (cfg_limit),
      .cfg_div   (cfg_div),
      .cnt_val   (cnt_val),
      .cnt_step  (cnt_step),
      .cnt_dir   (cnt_dir),
      .cnt_clr   (cnt_clr),
      .busy      (busy),
      .done      (done),
      .state     (state)
   );

   always #5 clk = ~clk;

   // External counter driven by the sequencer.
   always @(posedge clk) begin
      if (rst || cnt_clr)  model <= 16'd0;
      else if (cnt_step)   model <= cnt_dir ? model - 16'd1 : model + 16'd1;
   end

   always @(negedge clk) begin
      if (mon_clear) begin
         step_cnt  <= 0;
         done_cnt  <= 0;
         clr_hi    <= 0;
         last_step <= -1;
         min_gap   <= 9999;
         max_gap   <= 0;
      end else begin
         if (cnt_step) begin
            if (last_step >= 0) begin
               if (cyc - last_step < min_gap) min_gap <= cyc - last_step;
               if (cyc - last_step > max_gap) max_gap <= cyc - last_step;
            end
            last_step <= cyc;
            step_cnt  <= step_cnt + 1;
         end
         if (done)    done_cnt <= done_cnt + 1;
         if (cnt_clr) clr_hi   <= clr_hi + 1;
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) cyc1();
   endtask

   task automatic clear_mon();
      mon_clear = 1'b1;
      @(negedge clk);
      #1;
      mon_clear = 1'b0;
      cyc1();
   endtask

   task automatic start_run(input logic dir, input logic mode, input logic [15:0] lim,
                            input logic [7:0] div);
      cfg_dir   = dir;
      cfg_mode  = mode;
      cfg_limit = lim;
      cfg_div   = div;
      cmd_start = 1'b1;
      cyc1();
      cmd_start = 1'b0;
   endtask

   task automatic pulse_stop();
      cmd_stop = 1'b1;
      cyc1();
      cmd_stop = 1'b0;
   endtask

   task automatic pulse_clear();
      cmd_clear = 1'b1;
      cyc1();
      cmd_clear = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) seen = 1'b1;
         else      cyc1();
      end
      check({tag, " done seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_steps(input string tag, input int n, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (step_cnt >= n) seen = 1'b1;
         else               cyc1();
      end
      check({tag, " steps reached"}, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;

      // Reset state
      wait_cycles(3);
      check("rst state", state, 0);
      check("rst busy", busy, 0);
      check("rst step", cnt_step, 0);
      check("rst clr", cnt_clr, 0);
      check("rst done", done, 0);
      check("rst dir", cnt_dir, 0);
      rst = 1'b0;
      cyc1();
      clear_mon();

      // Up, limit 5, div 1, one-shot; cfg changed while busy must not matter
      start_run(1'b0, 1'b0, 16'd5, 8'd1);
      check("t1 state clr", state, 1);
      check("t1 cnt_clr", cnt_clr, 1);
      check("t1 busy", busy, 1);
      cfg_limit = 16'd2;
      cfg_div   = 8'd7;
      wait_done("t1", 100);
      check("t1 val", cnt_val, 5);
      check("t1 steps", step_cnt, 5);
      check("t1 busy end", busy, 0);
      check("t1 state end", state, 0);
      wait_cycles(10);
      check("t1 steps after", step_cnt, 5);
      check("t1 done count", done_cnt, 1);
      check("t1 clr cycles", clr_hi, 2);
      check("t1 min gap", min_gap, 2);
      check("t1 max gap", max_gap, 2);

      // Down, limit 3, div 3 -> target FFFD, steps every 4 cycles
      clear_mon();
      start_run(1'b1, 1'b0, 16'd3, 8'd3);
      check("t2 dir at start", cnt_dir, 1);
      wait_done("t2", 200);
      check("t2 val", cnt_val, 16'hFFFD);
      check("t2 dir at done", cnt_dir, 1);
      check("t2 steps", step_cnt, 3);
      wait_cycles(2);
      check("t2 min gap", min_gap, 4);
      check("t2 max gap", max_gap, 4);
      check("t2 dir idle", cnt_dir, 1);

      // Auto-reload, limit 2, div 1: three runs
      clear_mon();
      start_run(1'b0, 1'b1, 16'd2, 8'd1);
      nd = 0;
      for (int i = 0; i < 300 && nd < 3; i++) begin
         if (done) begin
            nd++;
            check("t3 val at done", cnt_val, 2);
            check("t3 clr with done", cnt_clr, 1);
            check("t3 busy at done", busy, 1);
         end
         cyc1();
      end
      check("t3 runs", nd, 3);
      check("t3 steps", step_cnt, 6);
      check("t3 reload clr", cnt_clr, 1);
      pulse_clear();
      check("t3 abort state", state, 1);
      check("t3 abort busy", busy, 0);
      wait_cycles(3);
      check("t3 idle", state, 0);
      check("t3 done total", done_cnt, 3);

      // Pause after 2 steps, hold, resume without relatching cfg
      clear_mon();
      start_run(1'b0, 1'b0, 16'd5, 8'd1);
      wait_steps("t4", 2, 100);
      pulse_stop();
      check("t4 paused", state, 3);
      check("t4 busy", busy, 1);
      wait_cycles(10);
      check("t4 steps held", step_cnt, 2);
      check("t4 still paused", state, 3);
      check("t4 val held", cnt_val, 2);
      cfg_limit = 16'd9;
      cmd_start = 1'b1;
      cyc1();
      cmd_start = 1'b0;
      check("t4 resumed", state, 2);
      wait_done("t4", 100);
      check("t4 steps", step_cnt, 5);
      check("t4 val", cnt_val, 5);

      // Limit 0: done without steps; stop in IDLE ignored
      clear_mon();
      start_run(1'b0, 1'b0, 16'd0, 8'd1);
      wait_done("t5", 20);
      check("t5 steps", step_cnt, 0);
      check("t5 val", cnt_val, 0);
      cyc1();
      check("t5 done one cycle", done, 0);
      pulse_stop();
      check("t5 stop idle", state, 0);
      check("t5 stop busy", busy, 0);

      // Clear mid-run at step 4 of 10
      clear_mon();
      start_run(1'b0, 1'b0, 16'd10, 8'd1);
      wait_steps("t6", 4, 100);
      pulse_clear();
      check("t6 clr state", state, 1);
      check("t6 clr busy", busy, 0);
      check("t6 cnt_clr", cnt_clr, 1);
      wait_cycles(5);
      check("t6 idle", state, 0);
      check("t6 no done", done_cnt, 0);
      check("t6 steps", step_cnt, 4);
      check("t6 val", cnt_val, 0);

      // Reset mid-RUN
      clear_mon();
      start_run(1'b1, 1'b0, 16'd10, 8'd1);
      wait_cycles(8);
      check("t7 running", state, 2);
      rst = 1'b1;
      cyc1();
      check("t7 state", state, 0);
      check("t7 busy", busy, 0);
      check("t7 step", cnt_step, 0);
      check("t7 clr", cnt_clr, 0);
      check("t7 done", done, 0);
      check("t7 dir", cnt_dir, 0);
      rst = 1'b0;
      cyc1();

      // Stop and start in the same RUN cycle -> PAUSE
      start_run(1'b0, 1'b0, 16'd10, 8'd1);
      wait_cycles(4);
      check("t8 running", state, 2);
      cmd_stop  = 1'b1;
      cmd_start = 1'b1;
      cyc1();
      cmd_stop  = 1'b0;
      cmd_start = 1'b0;
      check("t8 paused", state, 3);
      check("t8 busy", busy, 1);
      pulse_clear();
      wait_cycles(3);
      check("t8 idle", state, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller for the 16-bit up/down counter datapath.
- Generates prescaled step pulses, sync-clear and direction for one external counter.
- Watches the counter value against a programmed limit and signals completion.
- Supports one-shot and auto-reload runs with start/stop/clear commands.

Parameters:
- CNT_W, 16, counter width (cnt_val, cfg_limit)
- PRESC_W, 8, prescaler divisor width
- CLR_CYC, 2, cycles cnt_clr is held; covers the counter's clear latency (counter shows 0 within CLR_CYC cycles)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_start  in  1  start/resume pulse
- cmd_stop  in  1  pause pulse
- cmd_clear  in  1  abort and clear pulse
- cfg_dir  in  1  0=up, 1=down; latched at start from IDLE/DONE
- cfg_mode  in  1  0=one-shot, 1=auto-reload; latched at start
- cfg_limit  in  CNT_W  steps per run; latched at start
- cfg_div  in  PRESC_W  one step every (div+1) cycles; 0 treated as 1; latched at start
- cnt_val  in  CNT_W  current counter value
- cnt_step  out  1  one-cycle count-enable pulse to counter
- cnt_dir  out  1  direction to counter
- cnt_clr  out  1  sync clear request to counter
- busy  out  1  high in CLR(to run), RUN, PAUSE
- done  out  1  one-cycle pulse at terminal count
- state  out  2  IDLE=0, CLR=1, RUN=2, PAUSE=3; DONE reported as IDLE with done_flag

Behaviour:
- All outputs registered. Reset (rst high at clk edge, any state): state IDLE, cnt_step/cnt_clr/cnt_dir/done/busy 0, prescaler 0, latched cfg 0, done_flag 0.
- Command priority in one cycle: clear > stop > start.
- Target latched at start: up -> cfg_limit; down -> (0 - cfg_limit) mod 2^CNT_W.
- IDLE/DONE: start -> latch cfg, CLR with dest=RUN. clear -> CLR with dest=IDLE. Stop ignored.
- CLR: cnt_clr high exactly CLR_CYC cycles, cnt_step 0, then go to dest; prescaler zeroed on exit.
- RUN: prescaler counts 0..div_lat; at div_lat, cnt_step pulses 1 cycle and prescaler wraps to 0, unless cnt_val==target (step suppressed).
- Terminal: in RUN, cnt_val==target -> done pulse next cycle; one-shot -> DONE (done_flag=1, busy 0); auto-reload -> CLR with dest=RUN, same latched cfg.
- Minimum step spacing 2 cycles guarantees cnt_val settled before compare; no step ever issued past target.
- cfg_limit=0 -> done on first RUN cycle, zero steps.
- RUN stop -> PAUSE: prescaler and counter frozen, no steps. PAUSE start -> RUN resumes from held prescaler phase, cfg not relatched. PAUSE clear -> CLR dest=IDLE.
- RUN clear -> CLR dest=IDLE, no done pulse.
- cnt_dir = latched dir, stable from CLR entry to next start.
- cfg_* changes while busy have no effect.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_CLR, S_RUN, S_PAUSE), direction/mode constants, CNT_W default.
- One sub-module: seq_prescaler (load/zero, hold, tick at div value).
- FSM, target calc and compare stay in counter_sequencer.

Test Plan:
- Up, limit=5, div=1, one-shot: start -> cnt_clr 2 cycles, 5 cnt_step pulses 2 cycles apart, cnt_val 5, done 1 pulse, busy 0, no further steps.
- Down, limit=3, div=3: start -> target 16'hFFFD, steps every 4 cycles, done when cnt_val=FFFD, cnt_dir=1 throughout.
- Auto-reload, limit=2, div=1: 3 runs -> 3 done pulses, each followed by 2-cycle cnt_clr, cnt_val sequence 0,1,2,0,1,2...
- Pause: stop after 2 steps, hold 10 cycles -> no steps, state=3; start -> resumes, done after 3 more steps.
- Limit=0, plus clear mid-run at step 4 of limit 10 -> immediate done, zero steps; clear -> CLR then IDLE, no done.
- Reset asserted mid-RUN -> next cycle all outputs 0, state IDLE; stop+start same cycle in RUN -> PAUSE.
